aes_sub_bytes_seq: RTL and testbench

//  Forward (encrypt-direction) SubBytes engine, counterpart of the invSubBytes decrypt path.

---
 rtl/aes_sub_bytes_seq.sv | 139 +++++++++++++
 tb/tb_aes_sub_bytes_seq.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_sub_bytes_seq.sv
// Iterative forward AES SubBytes engine: BYTES_PER_CYCLE S-boxes per cycle, valid/ready on both sides.
// Optional feature: define AES_SUB_BYTES_SHIFT_ROWS_EN to fold ShiftRows into the output register load.
module aes_sub_bytes_seq #(
    parameter int BYTES_PER_CYCLE = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data
);

    localparam int N     = 16 / BYTES_PER_CYCLE;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    generate
        if (!(BYTES_PER_CYCLE == 1 || BYTES_PER_CYCLE == 2 || BYTES_PER_CYCLE == 4 ||
              BYTES_PER_CYCLE == 8 || BYTES_PER_CYCLE == 16)) begin : g_bad_bpc
            $error("aes_sub_bytes_seq: BYTES_PER_CYCLE must be 1, 2, 4, 8 or 16");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    // GF(2^8) multiply modulo x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Forward S-box: multiplicative inverse as a^254 (maps 0 to 0), then the affine transform.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] x;
        sq = gf_mul(a, a);
        x  = sq;
        for (int i = 0; i < 6; i++) begin
            sq = gf_mul(sq, sq);
            x  = gf_mul(x, sq);
        end
        return x ^ {x[6:0], x[7]} ^ {x[5:0], x[7:6]} ^ {x[4:0], x[7:5]} ^ {x[3:0], x[7:4]} ^ 8'h63;
    endfunction

`ifdef AES_SUB_BYTES_SHIFT_ROWS_EN
    // Output byte 4c+r takes input byte 4*((c+r) mod 4)+r.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
            end
        end
        return o;
    endfunction
`endif

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [127:0]       work;
    logic [127:0]       work_next;
    logic [127:0]       result_next;
    logic               last_chunk;

    assign last_chunk = (cnt == CNT_W'(N - 1));

    // NOTE: every variable assigned in always_comb gets a full default first so no latch is inferred.
    always_comb begin
        work_next = work;
        for (int j = 0; j < BYTES_PER_CYCLE; j++) begin
            int idx;
            idx = int'(cnt) * BYTES_PER_CYCLE + j;
            work_next[127-8*idx -: 8] = sbox(work[127-8*idx -: 8]);
        end
    end

`ifdef AES_SUB_BYTES_SHIFT_ROWS_EN
    assign result_next = shift_rows(work_next);
`else
    assign result_next = work_next;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_data  <= '0;
            cnt       <= '0;
            work      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        work     <= in_data;
                        cnt      <= '0;
                        state    <= BUSY;
                        in_ready <= 1'b0;
                    end
                end
                BUSY: begin
                    work <= work_next;
                    if (last_chunk) begin
                        cnt       <= '0;
                        state     <= DONE;
                        out_valid <= 1'b1;
                        out_data  <= result_next;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (out_valid && out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_sub_bytes_seq.sv
// Self-checking bench for aes_sub_bytes_seq: vector table, handshake corner cases, random back-to-back run.
// Honours AES_SUB_BYTES_SHIFT_ROWS_EN in its reference model when the macro is defined.
module tb_aes_sub_bytes_seq;

    localparam logic [2047:0] SBOX_TAB = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

    typedef struct {
        string        name;
        logic [127:0] din;
        logic [127:0] dout;
    } vec_t;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid, in_ready, out_valid, out_ready;
    logic [127:0] in_data, out_data;
    logic         iv1, ir1, ov1, or1;
    logic [127:0] od1;
    logic         iv16, ir16, ov16, or16;
    logic [127:0] od16;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    aes_sub_bytes_seq #(.BYTES_PER_CYCLE(4)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data));

    aes_sub_bytes_seq #(.BYTES_PER_CYCLE(1)) dut1 (
        .clk(clk), .reset(reset), .in_valid(iv1), .in_ready(ir1), .in_data(in_data),
        .out_valid(ov1), .out_ready(or1), .out_data(od1));

    aes_sub_bytes_seq #(.BYTES_PER_CYCLE(16)) dut16 (
        .clk(clk), .reset(reset), .in_valid(iv16), .in_ready(ir16), .in_data(in_data),
        .out_valid(ov16), .out_ready(or16), .out_data(od16));

    function automatic logic [7:0] sb(input logic [7:0] b);
        logic [2047:0] t;
        t = SBOX_TAB;
        return t[2047-8*int'(b) -: 8];
    endfunction

    // Reference: table lookup per byte, then optional row rotation on the 4x4 byte matrix.
    function automatic logic [127:0] model(input logic [127:0] s);
        logic [7:0]   st [16];
        logic [7:0]   o  [16];
        logic [127:0] r;
        for (int k = 0; k < 16; k++) st[k] = sb(s[127-8*k -: 8]);
        for (int c = 0; c < 4; c++) begin
            for (int row = 0; row < 4; row++) begin
`ifdef AES_SUB_BYTES_SHIFT_ROWS_EN
                o[4*c+row] = st[4*((c+row)%4)+row];
`else
                o[4*c+row] = st[4*c+row];
`endif
            end
        end
        for (int k = 0; k < 16; k++) r[127-8*k -: 8] = o[k];
        return r;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Returns at posedge+1 of the accept edge; in_data is scrambled right after it.
    task automatic accept(input logic [127:0] d);
        int k;
        k = 0;
        while (!in_ready && k < 50) begin
            tick();
            k++;
        end
        check("accept_ready", in_ready, 1);
        in_valid = 1'b1;
        in_data  = d;
        tick();
        in_valid = 1'b0;
        in_data  = rnd128();
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
    endtask

    task automatic run_check(input string name, input logic [127:0] d, input logic [127:0] exp);
        int lat;
        accept(d);
        wait_out(lat);
        check({name, "_latency"}, lat, 4);
        check({name, "_data"}, out_data, exp);
        check({name, "_in_ready_low"}, in_ready, 0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({name, "_out_valid_drop"}, out_valid, 0);
        check({name, "_in_ready_back"}, in_ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t         vecs [4];
        logic [127:0] d, exp, pat, pat_exp, held;
        int           lat, l1, l4, l16;

        vecs[0] = '{"zero",  128'h0, {16{8'h63}}};
`ifdef AES_SUB_BYTES_SHIFT_ROWS_EN
        vecs[1] = '{"fips",  128'h193de3bea0f4e22b9ac68d2ae9f84808, 128'hd4bf5d30e0b452aeb84111f11e2798e5};
`else
        vecs[1] = '{"fips",  128'h193de3bea0f4e22b9ac68d2ae9f84808, 128'hd42711aee0bf98f1b8b45de51e415230};
`endif
        vecs[2] = '{"order", {4{32'h000153ff}}, {4{32'h637ced16}}};
        vecs[3] = '{"ones",  {16{8'hff}}, {16{8'h16}}};

        reset = 1'b1;
        in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        iv1 = 1'b0; or1 = 1'b0; iv16 = 1'b0; or16 = 1'b0;
        tick();
        tick();
        check("reset_in_ready", in_ready, 1);
        check("reset_out_valid", out_valid, 0);
        check("reset_out_data", out_data, 0);
        reset = 1'b0;
        tick();

        // Reset pulse in the middle of a run, then the all-zero state.
        accept(rnd128());
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        check("midrun_reset_out_valid", out_valid, 0);
        run_check("zero_after_reset", 128'h0, {16{8'h63}});

        for (int i = 0; i < 4; i++) run_check(vecs[i].name, vecs[i].din, vecs[i].dout);

        // Byte order and latency for 1, 4 and 16 bytes per cycle, started on the same edge.
        pat     = {4{32'h000153ff}};
        pat_exp = {4{32'h637ced16}};
        in_data = pat; in_valid = 1'b1; iv1 = 1'b1; iv16 = 1'b1;
        tick();
        in_valid = 1'b0; iv1 = 1'b0; iv16 = 1'b0; in_data = rnd128();
        l1 = -1; l4 = -1; l16 = -1;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (ov1 && l1 < 0) l1 = c;
            if (out_valid && l4 < 0) l4 = c;
            if (ov16 && l16 < 0) l16 = c;
        end
        check("sweep_bpc1_latency", l1, 16);
        check("sweep_bpc4_latency", l4, 4);
        check("sweep_bpc16_latency", l16, 1);
        check("sweep_bpc1_data", od1, pat_exp);
        check("sweep_bpc4_data", out_data, pat_exp);
        check("sweep_bpc16_data", od16, pat_exp);
        out_ready = 1'b1; or1 = 1'b1; or16 = 1'b1;
        tick();
        out_ready = 1'b0; or1 = 1'b0; or16 = 1'b0;
        check("sweep_bpc1_drop", ov1, 0);
        check("sweep_bpc16_drop", ov16, 0);

        // Backpressure: result must hold and new requests must be ignored.
        d = rnd128();
        exp = model(d);
        accept(d);
        wait_out(lat);
        check("bp_latency", lat, 4);
        held = out_data;
        check("bp_data", held, exp);
        in_valid = 1'b1;
        for (int c = 0; c < 20; c++) begin
            in_data = rnd128();
            tick();
            check("bp_out_valid", out_valid, 1);
            check("bp_out_data", out_data, exp);
            check("bp_in_ready", in_ready, 0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp_release_out_valid", out_valid, 0);
        check("bp_release_in_ready", in_ready, 1);
        tick();
        check("bp_no_ghost_accept", in_ready, 1);

        // Asynchronous reset on the second BUSY cycle, checked before the next edge.
        accept(rnd128());
        tick();
        #2 reset = 1'b1;
        #1;
        check("busy_reset_in_ready", in_ready, 1);
        check("busy_reset_out_valid", out_valid, 0);
        check("busy_reset_out_data", out_data, 0);
        tick();
        reset = 1'b0;
        d = rnd128();
        run_check("after_busy_reset", d, model(d));

        // Asynchronous reset while a result waits in DONE.
        accept(rnd128());
        wait_out(lat);
        #2 reset = 1'b1;
        #1;
        check("done_reset_out_valid", out_valid, 0);
        check("done_reset_out_data", out_data, 0);
        tick();
        reset = 1'b0;
        tick();

        // Back-to-back random states: accept edge, N substitution edges, handshake edge,
        // then the next accept edge, so output handshakes are N+2 = 6 edges apart.
        begin
            logic [127:0] q [$];
            int           t, last_t, got;
            logic         acc, hs;
            t = 0; last_t = -1; got = 0;
            in_data = rnd128(); in_valid = 1'b1; out_ready = 1'b1;
            while (got < 8 && t < 300) begin
                @(negedge clk);
                acc = in_valid && in_ready;
                hs  = out_valid && out_ready;
                if (acc) q.push_back(model(in_data));
                if (hs) begin
                    if (q.size() == 0) check("b2b_unexpected_output", out_data, 'x);
                    else check("b2b_data", out_data, q.pop_front());
                    if (last_t >= 0) check("b2b_spacing", t - last_t, 6);
                    last_t = t;
                    got++;
                end
                tick();
                t++;
                if (acc) in_data = rnd128();
            end
            in_valid = 1'b0;
            out_ready = 1'b0;
            check("b2b_result_count", got, 8);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
